nd_2to1: RTL and testbench

ND_2TO1 -- requirements
Module: nd_2to1

---
 rtl/nd_2to1.sv | 170 +++++++++++++++++
 tb/tb_nd_2to1.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_2to1.sv
// nd_2to1: merges two four-phase handshake input channels into one output
// channel. Each input owns a one-entry buffer; a three-state output FSM
// forwards buffered messages, using a priority pointer when both are full.
// Optional feature macro: NS_ND_2TO1_SYNC_EN adds 2-flop synchronizers on
// rcv0_req, rcv1_req and snd0_ack (all handshake latencies grow by 2).
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

module nd_2to1 #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE,
  localparam int MSZ = ASZ + DSZ + RSZ
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic [MSZ-1:0] rcv0_data,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  input  logic [MSZ-1:0] rcv1_data,
  input  logic           rcv1_req,
  output logic           rcv1_ack,
  output logic [MSZ-1:0] snd0_data,
  output logic           snd0_req,
  input  logic           snd0_ack
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_t;

  logic [1:0]     req_raw;
  logic [1:0]     req_s;
  logic           sack_s;

  assign req_raw = {rcv1_req, rcv0_req};

`ifdef NS_ND_2TO1_SYNC_EN
  logic [1:0] req_p0, req_p1;
  logic       sack_p0, sack_p1;

  // Two-flop synchronizers on the handshake inputs
  always_ff @(posedge i_clk) begin
    if (reset) begin
      req_p0  <= '0;
      req_p1  <= '0;
      sack_p0 <= 1'b0;
      sack_p1 <= 1'b0;
    end else begin
      req_p0  <= req_raw;
      req_p1  <= req_p0;
      sack_p0 <= snd0_ack;
      sack_p1 <= sack_p0;
    end
  end

  assign req_s  = req_p1;
  assign sack_s = sack_p1;
`else
  assign req_s  = req_raw;
  assign sack_s = snd0_ack;
`endif

  logic [1:0]     rack_q;
  logic [1:0]     full_q;
  logic [1:0]     cap;
  logic [1:0]     clr;
  logic [MSZ-1:0] rdata  [2];
  logic [MSZ-1:0] mbuf_q [2];

  assign rdata[0] = rcv0_data;
  assign rdata[1] = rcv1_data;
  assign rcv0_ack = rack_q[0];
  assign rcv1_ack = rack_q[1];

  // A capture needs a fresh request (ack low) and an empty buffer
  assign cap = req_s & ~rack_q & ~full_q;

  // Per-input acknowledge and full flag; clear and capture never coincide
  // because a clear needs the buffer full and a capture needs it empty
  always_ff @(posedge i_clk) begin
    if (reset) begin
      rack_q <= '0;
      full_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) begin
          rack_q[i] <= 1'b1;
          full_q[i] <= 1'b1;
        end else begin
          if (rack_q[i] && !req_s[i]) rack_q[i] <= 1'b0;
          if (clr[i])                 full_q[i] <= 1'b0;
        end
      end
    end
  end

  // Message storage, written only on capture (validity is held by full_q)
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) mbuf_q[i] <= rdata[i];
    end
  end

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           ptr_q, ptr_d;
  logic           gsel;
  logic           sreq_d;
  logic [MSZ-1:0] sdata_d;

  // Output FSM state, grant, pointer and output message registers
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      ptr_q     <= 1'b0;
      snd0_req  <= 1'b0;
      snd0_data <= '0;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      snd0_req  <= sreq_d;
      snd0_data <= sdata_d;
      ready     <= 1'b1;
    end
  end

  // Arbitration and output handshake; pointer only moves on contention
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    sreq_d  = snd0_req;
    sdata_d = snd0_data;
    clr     = '0;
    gsel    = (&full_q) ? ptr_q : full_q[1];
    unique case (state_q)
      IDLE: begin
        if (|full_q) begin
          grant_d = gsel;
          sdata_d = mbuf_q[gsel];
          sreq_d  = 1'b1;
          state_d = SEND;
          if (&full_q) ptr_d = ~gsel;
        end
      end
      SEND: begin
        if (sack_s) begin
          sreq_d       = 1'b0;
          clr[grant_q] = 1'b1;
          state_d      = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!sack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nd_2to1.sv
// tb_nd_2to1: randomized and directed bench for nd_2to1 with a per-input
// message-queue reference model and a per-cycle output checker.
module tb_nd_2to1;
  localparam int ASZ   = 8;
  localparam int DSZ   = 8;
  localparam int RSZ   = 8;
  localparam int MSZ   = ASZ + DSZ + RSZ;
  localparam int BOUND = 300;
`ifdef NS_ND_2TO1_SYNC_EN
  localparam int SYN = 2;
`else
  localparam int SYN = 0;
`endif

  logic           i_clk = 1'b0;
  logic           reset = 1'b1;
  logic           ready;
  logic [MSZ-1:0] rcv0_data = '0;
  logic           rcv0_req  = 1'b0;
  logic           rcv0_ack;
  logic [MSZ-1:0] rcv1_data = '0;
  logic           rcv1_req  = 1'b0;
  logic           rcv1_ack;
  logic [MSZ-1:0] snd0_data;
  logic           snd0_req;
  logic           snd0_ack;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;

  // reference model: messages accepted per input, in acceptance order
  logic [MSZ-1:0] q0[$];
  logic [MSZ-1:0] q1[$];
  logic [MSZ-1:0] out_log[$];

  int  ack_max  = 0;
  bit  hold_ack = 1'b0;
  int  dly      = 0;

  nd_2to1 #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .ready     (ready),
    .rcv0_data (rcv0_data),
    .rcv0_req  (rcv0_req),
    .rcv0_ack  (rcv0_ack),
    .rcv1_data (rcv1_data),
    .rcv1_req  (rcv1_req),
    .rcv1_ack  (rcv1_ack),
    .snd0_data (snd0_data),
    .snd0_req  (snd0_req),
    .snd0_ack  (snd0_ack)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [MSZ-1:0] mk(input logic [7:0] a, input logic [7:0] d);
    return {a, d, ~d};
  endfunction

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic chk_m(input string nm, input logic [MSZ-1:0] act, input logic [MSZ-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // downstream responder: ack after a random delay, drop when req drops
  initial begin
    snd0_ack = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (snd0_ack) begin
        if (!snd0_req) begin
          snd0_ack = 1'b0;
          dly = int'($urandom_range(0, ack_max));
        end
      end else if (snd0_req && !hold_ack) begin
        if (dly == 0) snd0_ack = 1'b1;
        else dly--;
      end
    end
  end

  logic rst_at_edge = 1'b1;
  bit   seen_edge   = 1'b0;
  always @(posedge i_clk) begin
    rst_at_edge <= reset;
    seen_edge   <= 1'b1;
  end

  logic           prev_req  = 1'b0;
  logic [MSZ-1:0] prev_data = '0;
  logic [MSZ-1:0] e_msg;
  int             src;
  bit             none_pending;

  // per-cycle compare against the model
  always @(negedge i_clk) begin
    if (seen_edge) begin
      if (rst_at_edge) begin
        chk_b("rst_ready", ready, 1'b0);
        chk_b("rst_snd_req", snd0_req, 1'b0);
        chk_b("rst_ack0", rcv0_ack, 1'b0);
        chk_b("rst_ack1", rcv1_ack, 1'b0);
      end else begin
        chk_b("ready_high", ready, 1'b1);
        if (snd0_req && !prev_req) begin
          none_pending = (q0.size() == 0) && (q1.size() == 0);
          n_out++;
          out_log.push_back(snd0_data);
          if (none_pending) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %h required no request", snd0_data);
          end else begin
            src = -1;
            if (q0.size() > 0 && snd0_data === q0[0]) src = 0;
            else if (q1.size() > 0 && snd0_data === q1[0]) src = 1;
            if (src == 0) e_msg = q0.pop_front();
            else if (src == 1) e_msg = q1.pop_front();
            else e_msg = (q0.size() > 0) ? q0[0] : q1[0];
            chk_m("out_msg", snd0_data, e_msg);
          end
        end else if (snd0_req && prev_req) begin
          chk_m("data_stable", snd0_data, prev_data);
        end
      end
    end
    prev_req  = snd0_req;
    prev_data = snd0_data;
  end

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? rcv0_ack : rcv1_ack;
  endfunction

  // one four-phase transfer on an input channel
  task automatic send(input int ch, input logic [MSZ-1:0] m);
    int t;
    @(posedge i_clk); #1;
    if (ch == 0) begin rcv0_data = m; rcv0_req = 1'b1; end
    else begin rcv1_data = m; rcv1_req = 1'b1; end
    t = 0;
    while (ack_of(ch) !== 1'b1 && t < BOUND) begin
      @(posedge i_clk); #1;
      t++;
    end
    n_cmp++;
    if (t >= BOUND) begin
      n_fail++;
      $display("FAIL send_ack_timeout: ch%0d ack %b required 1", ch, ack_of(ch));
    end else begin
      if (ch == 0) q0.push_back(m);
      else q1.push_back(m);
    end
    if (ch == 0) rcv0_req = 1'b0;
    else rcv1_req = 1'b0;
    t = 0;
    while (ack_of(ch) !== 1'b0 && t < BOUND) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (t >= BOUND) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_ack_low_timeout: ch%0d ack %b required 0", ch, ack_of(ch));
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || snd0_req || snd0_ack) && t < 4*BOUND) begin
      @(posedge i_clk); #1;
      t++;
    end
    n_cmp++;
    if (t >= 4*BOUND) begin
      n_fail++;
      $display("FAIL drain_timeout: pending %0d/%0d required 0/0", q0.size(), q1.size());
    end
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  task automatic measure(output int an, output int rn, output bit bad1);
    an = -1; rn = -1; bad1 = 1'b0;
    @(posedge i_clk); #1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge i_clk); #1;
      if (rcv0_ack && an < 0) an = n;
      if (snd0_req && rn < 0) rn = n;
      if (rcv1_ack) bad1 = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  an, rn, base, t;
    bit  bad1, c_done;

    // reset for two cycles
    repeat (2) @(posedge i_clk);
    #1 reset = 1'b0;
    @(posedge i_clk); #1;
    chk_b("ready_after_reset", ready, 1'b1);
    chk_b("idle_snd_req", snd0_req, 1'b0);

    // single message on channel 0: latency and payload
    fork
      send(0, mk(8'h01, 8'h2A));
      measure(an, rn, bad1);
    join
    chk_m("single_ack_lat", MSZ'(an), MSZ'(1 + SYN));
    chk_m("single_req_lat", MSZ'(rn), MSZ'(2 + SYN));
    chk_b("single_ack1_quiet", bad1, 1'b0);
    wait_idle();
    chk_m("single_payload", out_log[out_log.size()-1], 24'h012AD5);

    // contention: pointer at input 0, then at input 1
    base = out_log.size();
    fork
      send(0, mk(8'h00, 8'h11));
      send(1, mk(8'h00, 8'h22));
    join
    wait_idle();
    chk_m("cont1_first", out_log[base], 24'h0011EE);
    chk_m("cont1_second", out_log[base+1], 24'h0022DD);
    base = out_log.size();
    fork
      send(0, mk(8'h00, 8'h11));
      send(1, mk(8'h00, 8'h22));
    join
    wait_idle();
    chk_m("cont2_first", out_log[base], 24'h0022DD);
    chk_m("cont2_second", out_log[base+1], 24'h0011EE);

    // backpressure: both buffers full, third ch0 request must wait
    hold_ack = 1'b1;
    send(0, mk(8'h30, 8'h5A));
    send(1, mk(8'h31, 8'hA5));
    c_done = 1'b0;
    fork
      begin
        send(0, mk(8'h32, 8'h3C));
        c_done = 1'b1;
      end
    join_none
    repeat (50) begin
      @(posedge i_clk); #1;
      chk_b("bp_no_ack", rcv0_ack, 1'b0);
    end
    hold_ack = 1'b0;
    t = 0;
    while (!c_done && t < BOUND) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk_b("bp_third_done", c_done, 1'b1);
    wait_idle();

    // reset while the output is in SEND
    hold_ack = 1'b1;
    send(0, mk(8'h40, 8'h77));
    repeat (2) @(posedge i_clk);
    #1;
    chk_b("mid_pre_req", snd0_req, 1'b1);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge i_clk); #1;
    chk_b("mid_req_low", snd0_req, 1'b0);
    chk_b("mid_ack0_low", rcv0_ack, 1'b0);
    chk_b("mid_ack1_low", rcv1_ack, 1'b0);
    chk_b("mid_ready_low", ready, 1'b0);
    @(posedge i_clk); #1;
    reset = 1'b0;
    hold_ack = 1'b0;
    repeat (20) begin
      @(posedge i_clk); #1;
      chk_b("post_rst_no_out", snd0_req, 1'b0);
    end
    send(1, mk(8'h41, 8'h99));
    wait_idle();

    // random stream: 56 messages, addresses 0..55 alternating inputs
    ack_max = 10;
    base = n_out;
    fork
      begin
        for (int a = 0; a < 56; a += 2) begin
          send(0, mk(a[7:0], 8'($urandom)));
          repeat ($urandom_range(0, 3)) @(posedge i_clk);
        end
      end
      begin
        for (int b = 1; b < 56; b += 2) begin
          send(1, mk(b[7:0], 8'($urandom)));
          repeat ($urandom_range(0, 3)) @(posedge i_clk);
        end
      end
    join
    wait_idle();
    chk_m("stream_count", MSZ'(n_out - base), MSZ'(56));
    chk_m("stream_q_empty", MSZ'(q0.size() + q1.size()), MSZ'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
